link_rx: RTL
============

LINK_RX -- requirements
Module: link_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 651, is the number of clk cycles per UART bit (75 MHz / 115200 baud).
REQ-002 Parameter TIMEOUT_CYCLES, default 75_000_000, is the number of idle cycles without a valid byte before the link is declared lost.
REQ-003 Port clk, input, 1 bit: 75 MHz system clock; the block has one clock, and all state is in this domain.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port rx, input, 1 bit: serial line from the peer board, asynchronous, idle high.
REQ-006 Port dir2, output, direction (snake_pkg): last direction received from the peer.
REQ-007 Port rcvdir, output, 1 bit: one-cycle pulse when dir2 is updated.
REQ-008 Port seed_x_out and seed_y_out, outputs, 6 bits each: last complete seed pair received.
REQ-009 Port seed_vld, output, 1 bit: one-cycle pulse when a new seed pair is presented.
REQ-010 Port start_game, output, 1 bit: one-cycle pulse when a START byte is received.
REQ-011 Port frame_err, output, 1 bit: one-cycle pulse when a stop bit is read as 0.
REQ-012 Port con_error, output, 1 bit: sticky link-lost flag.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Byte receiver FSM SHALL have states IDLE, START, DATA and STOP.
REQ-015 IDLE -> START SHALL occur on a synchronized low level.
REQ-016 START SHALL resample rx at CLKS_PER_BIT/2: low -> DATA; high -> IDLE as a glitch, with no output and no error.
REQ-017 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT after the previous sample (mid-bit).
REQ-018 STOP SHALL sample one bit at mid-bit: 1 -> byte valid; 0 -> frame_err pulse, byte discarded, then wait in IDLE for rx high before the next start detect.
REQ-019 Decode SHALL act on a valid byte in the cycle after the stop-bit sample; the pulse outputs assert in that same cycle (latency 1).
REQ-020 Decode SHALL use byte[7:6] as type: 00 DIR, 01 SEED_X, 10 SEED_Y, 11 START.
REQ-021 DIR: dir2 <= byte[1:0] cast to direction, and rcvdir pulses; byte[5:2] is ignored.
REQ-022 SEED_X: byte[5:0] goes to an internal x register, and the pending flag is set; a repeated SEED_X overwrites the register.
REQ-023 SEED_Y with pending set: seed_x_out <= x register, seed_y_out <= byte[5:0], seed_vld pulses, and pending clears.
REQ-024 SEED_Y without pending: the byte is discarded, with no pulse.
REQ-025 START: start_game pulses, and pending clears.
REQ-026 At most one pulse output SHALL be high in any cycle.
REQ-027 A frame_err SHALL NOT alter pending or any data output.
REQ-028 The idle counter SHALL clear on every valid byte and saturate at TIMEOUT_CYCLES.
REQ-029 When the idle counter reaches TIMEOUT_CYCLES, con_error SHALL go high and remain high until reset.
REQ-030 Bytes received after con_error is set SHALL still be decoded.
REQ-031 rx held low indefinitely SHALL produce repeated frame_err pulses only, one per frame period, followed by a wait for high.

Reset
REQ-032 Reset SHALL put both FSMs in IDLE, clear the counters, set the synchronizer flops to 1, and clear pending and the x register.
REQ-033 Reset SHALL drive dir2 to the direction encoding 2'b00, seed_x_out and seed_y_out to 0, and rcvdir, seed_vld, start_game, frame_err and con_error to 0.
REQ-034 Reset asserted mid-frame SHALL abort the byte with no output; after release, reception resumes only on a fresh falling edge.

Structure
REQ-035 The link_type enum (DIR, SEED_X, SEED_Y, START) and the default CLKS_PER_BIT SHALL be defined in snake_pkg, and the direction typedef SHALL be reused from there.
REQ-036 The serial deserializer SHALL be the sub-module uart_rx_byte (outputs data[7:0], valid pulse, frame_err pulse); link_rx SHALL hold the decode logic and the timeout.

Verification (CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000)
REQ-037 Send byte 0x02 -> rcvdir pulses one cycle after the stop sample, and dir2 = 2'b10.
REQ-038 Send 0x45 then 0x97 -> a single seed_vld pulse with seed_x_out=5 and seed_y_out=23.
REQ-039 Send 0x97 alone, then 0xC0 -> no seed_vld; start_game pulses once.
REQ-040 Send 0x02 with stop bit forced to 0 -> frame_err pulses, no rcvdir, and dir2 unchanged.
REQ-041 Send a low glitch of 4 cycles on rx -> no outputs; a following 0x01 is decoded normally, giving dir2 = 2'b01.
REQ-042 Hold rx high for 2000 cycles after reset -> con_error rises; a subsequent 0x03 still updates dir2, and con_error stays 1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake board-to-board serial link.
// Imported by the UART byte receiver and the link decoder.
package snake_pkg;

  // 75 MHz system clock / 115200 baud.
  localparam int unsigned DefaultClksPerBit = 651;

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } direction_t;

  typedef enum logic [1:0] {
    LinkDir   = 2'b00,
    LinkSeedX = 2'b01,
    LinkSeedY = 2'b10,
    LinkStart = 2'b11
  } link_type_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_t;

  function automatic link_type_t byte_type(input logic [7:0] b);
    return link_type_t'(b[7:6]);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte deserializer with input synchronizer and mid-bit sampling.
// valid/frame_err are decoded from the registered FSM state during the stop-bit sample cycle.
module uart_rx_byte
  import snake_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            wait_high_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      unique case (state_q)
        StIdle: begin
          // After a framing error the line must return high before a new start.
          if (rx_sync_q) begin
            wait_high_q <= 1'b0;
          end else if (!wait_high_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_sync_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (!rx_sync_q) wait_high_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic stop_hit;

  always_comb begin
    stop_hit  = (state_q == StStop) && (cnt_q == BitLast);
    valid     = stop_hit && rx_sync_q;
    frame_err = stop_hit && !rx_sync_q;
    data      = shift_q;
  end

endmodule

// File: rtl/link_rx.sv
// Peer-link receiver: decodes DIR / SEED_X / SEED_Y / START bytes from the UART
// and flags a lost link after TIMEOUT_CYCLES without a valid byte.
module link_rx
  import snake_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = DefaultClksPerBit,
  parameter int unsigned TIMEOUT_CYCLES = 75_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output direction_t dir2,
  output logic       rcvdir,
  output logic [5:0] seed_x_out,
  output logic [5:0] seed_y_out,
  output logic       seed_vld,
  output logic       start_game,
  output logic       frame_err,
  output logic       con_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT_CYCLES);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic [5:0]    x_q;
  logic          pending_q;
  logic [TW-1:0] idle_cnt_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx_byte (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir2       <= DirUp;
      rcvdir     <= 1'b0;
      seed_x_out <= '0;
      seed_y_out <= '0;
      seed_vld   <= 1'b0;
      start_game <= 1'b0;
      frame_err  <= 1'b0;
      con_error  <= 1'b0;
      x_q        <= '0;
      pending_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      rcvdir     <= 1'b0;
      seed_vld   <= 1'b0;
      start_game <= 1'b0;
      // valid and frame_err are exclusive, so at most one pulse fires per cycle.
      frame_err  <= rx_ferr;
      if (rx_valid) begin
        unique case (byte_type(rx_data))
          LinkDir: begin
            dir2   <= direction_t'(rx_data[1:0]);
            rcvdir <= 1'b1;
          end
          LinkSeedX: begin
            x_q       <= rx_data[5:0];
            pending_q <= 1'b1;
          end
          LinkSeedY: begin
            if (pending_q) begin
              seed_x_out <= x_q;
              seed_y_out <= rx_data[5:0];
              seed_vld   <= 1'b1;
              pending_q  <= 1'b0;
            end
          end
          LinkStart: begin
            start_game <= 1'b1;
            pending_q  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (rx_valid) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != TimeoutMax) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
      if (idle_cnt_q == TimeoutMax) con_error <= 1'b1;
    end
  end

endmodule
